vga_timing_gen: RTL and testbench

//  Generates 640x480 VGA raster timing (800x521 frame) from the 100 MHz system clock.
//  An internal 1-in-4 clock enable (pix_tick) sets a 25 MHz pixel rate.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_pix_tick_div.sv | 39 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and the sync/enable bundle.
//   Default timing (pixels/lines), derived totals and active-region start points.
//   timing_t carries {hs, vs, de} through the delay line and into the colour stage.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_ACT_DEF    = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 29;
  localparam int unsigned V_ACT_DEF    = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned PIPE_DLY_DEF = 1;

  localparam int unsigned H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;
  localparam int unsigned V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;
  localparam int unsigned H_ACT_START = H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_ACT_START = V_SYNC_DEF + V_BP_DEF;

  // Syncs are active low; de is active high
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } timing_t;

  // Idle (blanked, syncs inactive) value used for reset and pipeline fill
  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/vga_pix_tick_div.sv
// Pixel clock-enable divider: one-clk pix_tick every CLK_DIV system clocks.
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   pix_tick    out  registered enable, high while div_cnt == CLK_DIV-1
//   tick_next_c out  combinational look-ahead: pix_tick will be high next clk
module vga_pix_tick_div
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick,
  output logic tick_next_c
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;

  // Modulo-CLK_DIV count and tick look-ahead
  always_comb begin
    div_next = div_cnt + DW'(1);
    if (div_cnt == DW'(CLK_DIV - 1)) div_next = '0;
    tick_next_c = (div_next == DW'(CLK_DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      pix_tick <= tick_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (sync -> back porch -> active -> front porch).
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   pix_tick    out  pixel clock enable, one clk every CLK_DIV clks
//   hs, vs      out  active-low syncs, delayed PIPE_DLY ticks
//   de          out  active-video enable, delayed PIPE_DLY ticks
//   x, y        out  active column/row, 0 outside active region, undelayed
//   line_start  out  pulse with the pix_tick on which h_cnt wraps to 0
//   frame_start out  pulse with the pix_tick on which h_cnt and v_cnt both wrap
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned H_ACT    = H_ACT_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned V_ACT    = V_ACT_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HT      = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VT      = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HA_START = H_SYNC + H_BP;
  localparam int unsigned VA_START = V_SYNC + V_BP;
  localparam int unsigned HA_END   = HA_START + H_ACT;
  localparam int unsigned VA_END   = VA_START + V_ACT;
  // One spare value so the active-end bounds always fit
  localparam int unsigned HW = $clog2(HT + 1);
  localparam int unsigned VW = $clog2(VT + 1);

  logic          tick_next_c;
  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          h_wrap, v_wrap, h_act, v_act;
  timing_t       raw_next, raw_q;
  logic [9:0]    x_next, y_next;

  vga_pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst        (rst),
    .pix_tick   (pix_tick),
    .tick_next_c(tick_next_c)
  );

  // Next raster position and its decode
  always_comb begin
    h_wrap = (h_cnt == HW'(HT - 1));
    v_wrap = (v_cnt == VW'(VT - 1));
    h_next = h_wrap ? '0 : h_cnt + HW'(1);
    v_next = v_cnt;
    if (h_wrap) v_next = v_wrap ? '0 : v_cnt + VW'(1);
    h_act = (h_next >= HW'(HA_START)) && (h_next < HW'(HA_END));
    v_act = (v_next >= VW'(VA_START)) && (v_next < VW'(VA_END));
    raw_next.hs = (h_next >= HW'(H_SYNC));
    raw_next.vs = (v_next >= VW'(V_SYNC));
    raw_next.de = h_act && v_act;
    x_next = '0;
    y_next = '0;
    if (raw_next.de) begin
      x_next = 10'(h_next - HW'(HA_START));
      y_next = 10'(v_next - VW'(VA_START));
    end
  end

  // Counters and undelayed decode advance on pix_tick; start pulses ride with pix_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      raw_q       <= TIMING_IDLE;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= tick_next_c && h_wrap;
      frame_start <= tick_next_c && h_wrap && v_wrap;
      if (pix_tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        raw_q <= raw_next;
        x     <= x_next;
        y     <= y_next;
      end
    end
  end

  // Sync/enable delay line to match colour pipeline latency
  if (PIPE_DLY == 0) begin : g_no_dly
    assign hs = raw_q.hs;
    assign vs = raw_q.vs;
    assign de = raw_q.de;
  end else begin : g_dly
    timing_t dly_q [PIPE_DLY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) dly_q[i] <= TIMING_IDLE;
      end else if (pix_tick) begin
        dly_q[0] <= raw_q;
        for (int i = 1; i < int'(PIPE_DLY); i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign hs = dly_q[PIPE_DLY-1].hs;
    assign vs = dly_q[PIPE_DLY-1].vs;
    assign de = dly_q[PIPE_DLY-1].de;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster, PIPE_DLY 0 and 2 instances.
module tb_vga_timing_gen;

  localparam int D   = 4;
  localparam int HS  = 4, HBP = 3, HA = 8, HFP = 2;
  localparam int VS  = 2, VBP = 2, VA = 4, VFP = 1;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FT  = HT * VT;
  localparam int HAS = HS + HBP;
  localparam int VAS = VS + VBP;
  localparam int NCYC = 15000;

  typedef struct packed {
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pt0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pt2, hs2, vs2, de2, ls2, fs2;
  logic [9:0] x2, y2;

  vga_timing_gen #(
    .CLK_DIV(D), .H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP), .PIPE_DLY(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .pix_tick(pt0), .hs(hs0), .vs(vs0), .de(de0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(D), .H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP), .PIPE_DLY(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .pix_tick(pt2), .hs(hs2), .vs(vs2), .de(de2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
  );

  obs_t act0, act2;
  assign act0 = {pt0, ls0, fs0, hs0, vs0, de0, x0, y0};
  assign act2 = {pt2, ls2, fs2, hs2, vs2, de2, x2, y2};

  obs_t q0[$];
  obs_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;
  int   hold  = 0;

  function automatic logic in_act(int h, int v);
    return (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
  endfunction

  // Expected outputs after k clock edges since reset release, with sync delay d ticks.
  // n = pixel ticks consumed; raster position n (mod frame) has been visited.
  function automatic obs_t model(int kk, int d);
    obs_t o;
    int n, p, h, v, j;
    n = kk / D;
    o.pix_tick    = ((kk % D) == D - 1);
    o.line_start  = o.pix_tick && (((n + 1) % HT) == 0);
    o.frame_start = o.pix_tick && (((n + 1) % FT) == 0);
    o.x = '0;
    o.y = '0;
    if (n > 0) begin
      p = n % FT; h = p % HT; v = p / HT;
      if (in_act(h, v)) begin
        o.x = 10'(h - HAS);
        o.y = 10'(v - VAS);
      end
    end
    o.hs = 1'b1; o.vs = 1'b1; o.de = 1'b0;
    j = n - d;
    if (j > 0) begin
      p = j % FT; h = p % HT; v = p / HT;
      o.hs = (h >= HS);
      o.vs = (v >= VS);
      o.de = in_act(h, v);
    end
    return o;
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got tick=%b ls=%b fs=%b hs=%b vs=%b de=%b x=%0d y=%0d want tick=%b ls=%b fs=%b hs=%b vs=%b de=%b x=%0d y=%0d",
               nm, $time, a.pix_tick, a.line_start, a.frame_start, a.hs, a.vs, a.de, a.x, a.y,
               e.pix_tick, e.line_start, e.frame_start, e.hs, e.vs, e.de, e.x, e.y);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, a, e);
    end
  endtask

  // Stimulus: initial reset, then random asynchronous resets of 1..5 clks
  initial begin
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (!rst) k++;
      #2;
      if (c < 10) begin
        rst = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end else if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 999) == 0) begin
        rst  = 1'b1;
        hold = int'($urandom_range(1, 5));
      end
      if (rst) k = 0;
      q0.push_back(model(k, 0));
      q2.push_back(model(k, 2));
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compare every presented cycle, plus whole-frame period and de count
  int clk_since_fs = 0;
  int de_ticks     = 0;
  bit armed        = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) check("dut0", act0, q0.pop_front());
      if (q2.size() > 0) check("dut2", act2, q2.pop_front());
      if (rst) begin
        armed        = 1'b0;
        clk_since_fs = 0;
        de_ticks     = 0;
      end else begin
        clk_since_fs++;
        if (pt0 && de0) de_ticks++;
        if (fs0) begin
          if (armed) begin
            check_int("frame_period", clk_since_fs, FT * D);
            check_int("frame_de_ticks", de_ticks, HA * VA);
          end
          armed        = 1'b1;
          clk_since_fs = 0;
          de_ticks     = 0;
        end
      end
    end
  end

endmodule
